// File: rtl/sdram_echo_sequencer.sv
// Per-frame SDRAM delay-line sequencer: for each channel, read the delayed sample,
// mix it with the dry sample, write the new sample back, and publish the mix.
module sdram_echo_sequencer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned NCH      = 2,
  parameter int unsigned DEPTH_W  = 15,
  parameter int unsigned FB_SHIFT = 1
) (
  input  logic                   CLOCK_50_D,
  input  logic                   AUD_ADCLRCK,
  input  logic [NCH*DATA_W-1:0]  in_data,
  input  logic [DEPTH_W-1:0]     frame_idx,
  input  logic [NCH*DEPTH_W-1:0] delay,
  input  logic [1:0]             mode,
  input  logic                   mute,
  input  logic                   busy,
  input  logic                   rd_ready,
  input  logic [DATA_W-1:0]      rd_data,
  output logic                   rd_enable,
  output logic                   wr_enable,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic [NCH*DATA_W-1:0]  out_data,
  output logic [NCH-1:0]         out_valid,
  output logic                   done
);

  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, MIX, WR_REQ, WR_WAIT, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [DATA_W-1:0]      dry_q [NCH];
  logic [DATA_W-1:0]      dry_d [NCH];
  logic [DEPTH_W-1:0]     dly_q [NCH];
  logic [DEPTH_W-1:0]     dly_d [NCH];
  logic [1:0]             mode_q, mode_d;
  logic                   mute_q, mute_d;
  logic [DATA_W-1:0]      wet_q, wet_d;
  logic [DATA_W-1:0]      wr_val_q, wr_val_d;
  logic [DATA_W-1:0]      out_val_q, out_val_d;
  logic                   seen_q, seen_d;

  logic                   rd_enable_q, rd_enable_d;
  logic                   wr_enable_q, wr_enable_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;
  logic [NCH*DATA_W-1:0]  out_data_q, out_data_d;
  logic [NCH-1:0]         out_valid_q, out_valid_d;
  logic                   done_q, done_d;

  // Datapath for the active channel: wet scaling, widened sum, saturation, addresses
  logic [DATA_W-1:0]        dry_c;
  logic signed [DATA_W-1:0] sh_c;
  logic [DATA_W:0]          sum_c;
  logic [DATA_W-1:0]        sat_c;
  logic [DEPTH_W-1:0]       rd_off_c;
  logic [ADDR_W-1:0]        base_c;
  logic [ADDR_W-1:0]        rd_addr_c;
  logic [ADDR_W-1:0]        wr_addr_c;

  assign dry_c     = dry_q[ch_q];
  assign sh_c      = $signed(wet_q) >>> FB_SHIFT;
  assign sum_c     = {dry_c[DATA_W-1], dry_c} + {sh_c[DATA_W-1], sh_c};
  assign rd_off_c  = frame_idx - dly_q[ch_q];
  assign base_c    = ADDR_W'(ch_q) << DEPTH_W;
  assign rd_addr_c = base_c + ADDR_W'(rd_off_c);
  assign wr_addr_c = base_c + ADDR_W'(frame_idx);

  always_comb begin
    sat_c = sum_c[DATA_W-1:0];
    if (sum_c[DATA_W] != sum_c[DATA_W-1]) begin
      sat_c = sum_c[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // State and datapath registers; reset also aborts an overrunning frame
  always_ff @(posedge CLOCK_50_D or posedge AUD_ADCLRCK) begin
    if (AUD_ADCLRCK) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      for (int i = 0; i < NCH; i++) begin
        dry_q[i] <= '0;
        dly_q[i] <= '0;
      end
      mode_q      <= '0;
      mute_q      <= 1'b0;
      wet_q       <= '0;
      wr_val_q    <= '0;
      out_val_q   <= '0;
      seen_q      <= 1'b0;
      rd_enable_q <= 1'b0;
      wr_enable_q <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      dry_q       <= dry_d;
      dly_q       <= dly_d;
      mode_q      <= mode_d;
      mute_q      <= mute_d;
      wet_q       <= wet_d;
      wr_val_q    <= wr_val_d;
      out_val_q   <= out_val_d;
      seen_q      <= seen_d;
      rd_enable_q <= rd_enable_d;
      wr_enable_q <= wr_enable_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    dry_d       = dry_q;
    dly_d       = dly_q;
    mode_d      = mode_q;
    mute_d      = mute_q;
    wet_d       = wet_q;
    wr_val_d    = wr_val_q;
    out_val_d   = out_val_q;
    seen_d      = seen_q;
    rd_enable_d = 1'b0;
    wr_enable_d = 1'b0;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    out_data_d  = out_data_q;
    out_valid_d = '0;
    done_d      = done_q;

    case (state_q)
      IDLE: begin
        for (int i = 0; i < NCH; i++) begin
          dry_d[i] = in_data[i*DATA_W +: DATA_W];
          dly_d[i] = delay[i*DEPTH_W +: DEPTH_W];
        end
        mode_d  = mode;
        mute_d  = mute;
        state_d = RD_REQ;
      end
      RD_REQ: begin
        if (!busy) begin
          rd_enable_d = 1'b1;
          rd_addr_d   = rd_addr_c;
          state_d     = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_ready) begin
          wet_d   = rd_data;
          state_d = MIX;
        end
      end
      MIX: begin
        case (mode_q)
          2'b00:   begin out_val_d = dry_c; wr_val_d = dry_c; end
          2'b01:   begin out_val_d = wet_q; wr_val_d = dry_c; end
          2'b10:   begin out_val_d = sat_c; wr_val_d = dry_c; end
          default: begin out_val_d = sat_c; wr_val_d = sat_c; end
        endcase
        state_d = WR_REQ;
      end
      WR_REQ: begin
        if (!busy) begin
          wr_enable_d = 1'b1;
          wr_addr_d   = wr_addr_c;
          wr_data_d   = wr_val_q;
          for (int i = 0; i < NCH; i++) begin
            if (ch_q == CH_W'(i)) begin
              out_data_d[i*DATA_W +: DATA_W] = mute_q ? '0 : out_val_q;
              out_valid_d[i] = 1'b1;
            end
          end
          seen_d  = 1'b0;
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        // The write is complete once the controller has gone busy and come back idle
        if (!seen_q) begin
          if (busy) seen_d = 1'b1;
        end else if (!busy) begin
          seen_d = 1'b0;
          if (ch_q == LAST_CH) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            ch_d    = CH_W'(ch_q + 1'b1);
            state_d = RD_REQ;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd_enable = rd_enable_q;
  assign wr_enable = wr_enable_q;
  assign rd_addr   = rd_addr_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sdram_echo_sequencer.sv
// Directed bench for sdram_echo_sequencer with a simple ideal SDRAM controller model.
`timescale 1ns/1ps
module tb_sdram_echo_sequencer;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned NCH     = 2;
  localparam int unsigned DEPTH_W = 15;

  logic                   CLOCK_50_D = 1'b0;
  logic                   AUD_ADCLRCK;
  logic [NCH*DATA_W-1:0]  in_data;
  logic [DEPTH_W-1:0]     frame_idx;
  logic [NCH*DEPTH_W-1:0] delay;
  logic [1:0]             mode;
  logic                   mute;
  logic                   busy;
  logic                   rd_ready;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_enable, wr_enable;
  logic [ADDR_W-1:0]      rd_addr, wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic [NCH*DATA_W-1:0]  out_data;
  logic [NCH-1:0]         out_valid;
  logic                   done;

  sdram_echo_sequencer dut (
    .CLOCK_50_D (CLOCK_50_D),
    .AUD_ADCLRCK(AUD_ADCLRCK),
    .in_data    (in_data),
    .frame_idx  (frame_idx),
    .delay      (delay),
    .mode       (mode),
    .mute       (mute),
    .busy       (busy),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_enable  (rd_enable),
    .wr_enable  (wr_enable),
    .rd_addr    (rd_addr),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .done       (done)
  );

  always #10 CLOCK_50_D = ~CLOCK_50_D;

  typedef struct {
    logic [1:0]  mode;
    logic        mute;
    logic [14:0] fi, d0, d1;
    logic [15:0] dry0, dry1, wet0, wet1;
    logic [23:0] ra0, ra1, wa0, wa1;
    logic [15:0] wd0, wd1, o0, o1;
  } vec_t;

  vec_t vt [6];

  int n_chk = 0;
  int n_err = 0;

  // Controller model state
  logic        stall = 1'b0;
  logic        rdy_force = 1'b0;
  logic        pend_busy = 1'b0;
  logic        pend_rd = 1'b0;
  int          pend_ch = 0;
  int          ctl_rd_n = 0;
  logic [15:0] cur_wet [2];

  // Request log
  logic        ev_is_rd [16];
  logic [23:0] ev_addr  [16];
  logic [15:0] ev_data  [16];
  int          n_ev = 0;
  int          vcnt [2];
  logic [15:0] obs_out [2];
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Ideal controller: busy for one cycle after each request, read data one cycle later
  always @(posedge CLOCK_50_D) begin
    #1;
    busy     = stall | pend_busy;
    rd_ready = pend_rd | rdy_force;
    rd_data  = (pend_rd && pend_ch < 2) ? cur_wet[pend_ch] : 16'hDEAD;
    pend_busy = rd_enable | wr_enable;
    pend_rd   = rd_enable;
    if (rd_enable) begin
      pend_ch = ctl_rd_n;
      ctl_rd_n++;
    end
  end

  always @(negedge CLOCK_50_D) begin
    if (rd_enable || wr_enable) begin
      n_chk++;
      if ((rd_enable && wr_enable) || (rd_enable && prev_rd) || (wr_enable && prev_wr)) begin
        n_err++;
        $display("FAIL pulse_shape: rd_en %b wr_en %b prev_rd %b prev_wr %b",
                 rd_enable, wr_enable, prev_rd, prev_wr);
      end
      if (n_ev < 16) begin
        ev_is_rd[n_ev] = rd_enable;
        ev_addr[n_ev]  = rd_enable ? rd_addr : wr_addr;
        ev_data[n_ev]  = wr_data;
      end
      n_ev++;
    end
    for (int c = 0; c < 2; c++) begin
      if (out_valid[c]) begin
        vcnt[c]++;
        obs_out[c] = out_data[c*16 +: 16];
      end
    end
    prev_rd = rd_enable;
    prev_wr = wr_enable;
  end

  task automatic clear_log();
    n_ev = 0;
    for (int i = 0; i < 16; i++) begin
      ev_is_rd[i] = 1'b0;
      ev_addr[i]  = '0;
      ev_data[i]  = '0;
    end
    for (int c = 0; c < 2; c++) begin
      vcnt[c] = 0;
      obs_out[c] = '0;
    end
  endtask

  task automatic start_frame(input vec_t v);
    @(negedge CLOCK_50_D);
    AUD_ADCLRCK = 1'b1;
    stall       = 1'b0;
    in_data     = {v.dry1, v.dry0};
    delay       = {v.d1, v.d0};
    mode        = v.mode;
    mute        = v.mute;
    frame_idx   = v.fi;
    cur_wet[0]  = v.wet0;
    cur_wet[1]  = v.wet1;
    repeat (2) @(negedge CLOCK_50_D);
    clear_log();
    ctl_rd_n    = 0;
    AUD_ADCLRCK = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge CLOCK_50_D);
      cyc++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_frame(input vec_t v, input int vi, input bit chk_cyc, input int cyc);
    logic [23:0] ea [4];
    logic [15:0] ed [4];
    ea[0] = v.ra0; ea[1] = v.wa0; ea[2] = v.ra1; ea[3] = v.wa1;
    ed[1] = v.wd0; ed[3] = v.wd1;
    chk($sformatf("v%0d_num_requests", vi), 32'(n_ev), 32'd4);
    for (int e = 0; e < 4; e++) begin
      chk($sformatf("v%0d_req%0d_is_read", vi, e), 32'(ev_is_rd[e]), 32'((e % 2) == 0));
      chk($sformatf("v%0d_req%0d_addr", vi, e), 32'(ev_addr[e]), 32'(ea[e]));
      if (e % 2 == 1) chk($sformatf("v%0d_req%0d_wr_data", vi, e), 32'(ev_data[e]), 32'(ed[e]));
    end
    chk($sformatf("v%0d_valid_cnt0", vi), 32'(vcnt[0]), 32'd1);
    chk($sformatf("v%0d_valid_cnt1", vi), 32'(vcnt[1]), 32'd1);
    chk($sformatf("v%0d_out_at_valid0", vi), 32'(obs_out[0]), 32'(v.o0));
    chk($sformatf("v%0d_out_at_valid1", vi), 32'(obs_out[1]), 32'(v.o1));
    chk($sformatf("v%0d_out_final", vi), out_data, {v.o1, v.o0});
    if (chk_cyc) chk($sformatf("v%0d_done_cycle", vi), 32'(cyc), 32'd17);
  endtask

  initial begin
    int cyc;
    vt[0] = '{2'b10, 1'b0, 15'd100, 15'd10, 15'd20, 16'h1000, 16'h2000, 16'h0800, 16'h0800,
              24'h00005A, 24'h008050, 24'h000064, 24'h008064, 16'h1000, 16'h2000, 16'h1400, 16'h2400};
    vt[1] = '{2'b10, 1'b0, 15'd100, 15'd10, 15'd20, 16'h7000, 16'h8000, 16'h6000, 16'h8000,
              24'h00005A, 24'h008050, 24'h000064, 24'h008064, 16'h7000, 16'h8000, 16'h7FFF, 16'h8000};
    vt[2] = '{2'b11, 1'b1, 15'd100, 15'd10, 15'd20, 16'h0100, 16'h7000, 16'h0200, 16'h6000,
              24'h00005A, 24'h008050, 24'h000064, 24'h008064, 16'h0200, 16'h7FFF, 16'h0000, 16'h0000};
    vt[3] = '{2'b00, 1'b0, 15'd3, 15'd5, 15'd0, 16'h1234, 16'hFEDC, 16'h1111, 16'h2222,
              24'h007FFE, 24'h008003, 24'h000003, 24'h008003, 16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC};
    vt[4] = '{2'b01, 1'b0, 15'h7FFF, 15'h7FFF, 15'd1, 16'h0555, 16'h8001, 16'hABCD, 16'h0042,
              24'h000000, 24'h00FFFE, 24'h007FFF, 24'h00FFFF, 16'h0555, 16'h8001, 16'hABCD, 16'h0042};
    vt[5] = '{2'b10, 1'b0, 15'd50, 15'd50, 15'd49, 16'h0010, 16'hFFF0, 16'hFFFF, 16'h0003,
              24'h000000, 24'h008001, 24'h000032, 24'h008032, 16'h0010, 16'hFFF0, 16'h000F, 16'hFFF1};

    AUD_ADCLRCK = 1'b0;
    in_data = '0; frame_idx = '0; delay = '0; mode = '0; mute = 1'b0;
    busy = 1'b0; rd_ready = 1'b0; rd_data = '0;
    cur_wet[0] = '0; cur_wet[1] = '0;
    clear_log();
    #5 AUD_ADCLRCK = 1'b1;

    // Reset held with an idle controller and a stray rd_ready
    rdy_force = 1'b1;
    repeat (4) begin
      @(negedge CLOCK_50_D);
      chk("rst_enables", {30'd0, rd_enable, wr_enable}, 32'd0);
      chk("rst_addrs", 32'(rd_addr | wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_valid_done", {29'd0, out_valid, done}, 32'd0);
    end
    chk("rst_no_requests", 32'(n_ev), 32'd0);
    rdy_force = 1'b0;

    for (int i = 0; i < 6; i++) begin
      start_frame(vt[i]);
      wait_done(200, cyc);
      check_frame(vt[i], i, 1'b1, cyc);
      repeat (3) @(negedge CLOCK_50_D);
      chk($sformatf("v%0d_done_holds", i), 32'(done), 32'd1);
      chk($sformatf("v%0d_no_extra_requests", i), 32'(n_ev), 32'd4);
    end

    // Overrun: reset rises while the first read pulse is out and the FSM sits in RD_WAIT
    start_frame(vt[0]);
    repeat (2) @(negedge CLOCK_50_D);
    #2;
    chk("abort_pre_rd_enable", 32'(rd_enable), 32'd1);
    chk("abort_pre_rd_addr", 32'(rd_addr), 32'h00005A);
    AUD_ADCLRCK = 1'b1;
    #1;
    chk("abort_rd_enable", 32'(rd_enable), 32'd0);
    chk("abort_rd_addr", 32'(rd_addr), 32'd0);
    chk("abort_misc", {29'd0, out_valid, done}, 32'd0);
    repeat (3) @(negedge CLOCK_50_D);
    chk("abort_held_enables", {30'd0, rd_enable, wr_enable}, 32'd0);
    chk("abort_held_out", out_data, 32'd0);

    // Stall: busy held high for 50 cycles after the first read
    start_frame(vt[0]);
    repeat (2) @(negedge CLOCK_50_D);
    stall = 1'b1;
    repeat (50) @(negedge CLOCK_50_D);
    chk("stall_one_request", 32'(n_ev), 32'd1);
    chk("stall_not_done", 32'(done), 32'd0);
    chk("stall_no_wr_enable", 32'(wr_enable), 32'd0);
    stall = 1'b0;
    wait_done(200, cyc);
    check_frame(vt[0], 6, 1'b0, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
